// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/lap/clear buttons, run/pause/lap FSM,
// 0.1 s prescaler and a 4-digit BCD count presented live or frozen on lap.
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands,
    output logic       running,
    output logic       lap_active,
    output logic       wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    state_t          state, state_next;
    logic [2:0]      raw;
    logic [2:0]      sync_p0, sync_p1;
    logic [2:0]      level, level_d, press;
    logic [DW-1:0]   db_cnt [3];
    logic [PW-1:0]   presc;
    logic [15:0]     count, count_inc, count_next, lap_reg;
    logic            act_start, act_lap, act_clear;
    logic            counting, tick, lap_capture, do_clear;

    // Decimal increment with carry rippling through all four digits.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign raw = {btn_clear, btn_lap, btn_start};

    // Button stage: 2-flop sync, stability counter, registered rising-edge pulse
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            level   <= '0;
            level_d <= '0;
            press   <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            level_d <= level;
            press   <= level & ~level_d;
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    level[i]  <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only the highest-priority press of a cycle survives (start > lap > clear).
    assign act_start = press[0];
    assign act_lap   = press[1] & ~press[0];
    assign act_clear = press[2] & ~press[1] & ~press[0];

    always_ff @(posedge clk_100MHz) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        counting    = 1'b0;
        lap_capture = 1'b0;
        do_clear    = 1'b0;
        case (state)
            IDLE: begin
                if (act_start) state_next = RUN;
            end
            RUN: begin
                counting = 1'b1;
                if (act_start) begin
                    state_next = PAUSE;
                end else if (act_lap) begin
                    state_next  = LAP;
                    lap_capture = 1'b1;
                end
            end
            LAP: begin
                counting = 1'b1;
                if (act_start)    state_next = PAUSE;
                else if (act_lap) state_next = RUN;
            end
            PAUSE: begin
                if (act_start) begin
                    state_next = RUN;
                end else if (act_clear) begin
                    state_next = IDLE;
                    do_clear   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tick       = counting && (presc == PRESC_MAX);
    assign count_inc  = bcd_inc(count);
    assign count_next = tick ? count_inc : count;

    // Count stage: prescaler, BCD counter, lap capture (sees same-edge increment)
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            presc   <= '0;
            count   <= '0;
            lap_reg <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= tick && (count == 16'h9999);
            if (do_clear) begin
                presc   <= '0;
                count   <= '0;
                lap_reg <= '0;
            end else begin
                count <= count_next;
                if (counting)           presc <= tick ? '0 : presc + 1'b1;
                else if (state == IDLE) presc <= '0;
                if (lap_capture)        lap_reg <= count_next;
            end
        end
    end

    assign running    = (state == RUN) || (state == LAP);
    assign lap_active = (state == LAP);
    assign {thousands, hundreds, tens, ones} = lap_active ? lap_reg : count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed steps plus random button activity, compared
// every cycle against an integer-arithmetic model of the stopwatch.
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 10;
    localparam int DEB      = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_PAUSE = 3;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       btn_start  = 1'b0;
    logic       btn_lap    = 1'b0;
    logic       btn_clear  = 1'b0;
    logic [3:0] ones, tens, hundreds, thousands;
    logic       running, lap_active, wrap;

    logic       w_start = 1'b0;
    logic [3:0] w_ones, w_tens, w_hundreds, w_thousands;
    logic       w_running, w_lap_active, w_wrap;

    int checks = 0;
    int errors = 0;

    // Model state: counts and lap value as plain integers.
    int m_state, m_count, m_lap, m_phase;
    bit m_wrap;
    bit m_lvl   [3];
    bit m_rose  [3];
    bit m_pulse [3];
    bit m_hist  [3][16];

    always #5 clk_100MHz = ~clk_100MHz;

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .running(running), .lap_active(lap_active), .wrap(wrap)
    );

    // Fast-tick instance used to reach the 9999 -> 0000 rollover quickly.
    stopwatch_ctrl #(.TICK_DIV(2), .DEBOUNCE_CYCLES(DEB)) dut_w (
        .clk_100MHz(clk_100MHz), .reset(reset),
        .btn_start(w_start), .btn_lap(1'b0), .btn_clear(1'b0),
        .ones(w_ones), .tens(w_tens), .hundreds(w_hundreds), .thousands(w_thousands),
        .running(w_running), .lap_active(w_lap_active), .wrap(w_wrap)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] disp();
        return {thousands, hundreds, tens, ones};
    endfunction

    function automatic logic [15:0] w_disp();
        return {w_thousands, w_hundreds, w_tens, w_ones};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_count = 0;
        m_lap   = 0;
        m_phase = 0;
        m_wrap  = 1'b0;
        for (int b = 0; b < 3; b++) begin
            m_lvl[b] = 1'b0; m_rose[b] = 1'b0; m_pulse[b] = 1'b0;
            for (int k = 0; k < 16; k++) m_hist[b][k] = 1'b0;
        end
    endtask

    // One clock edge of the model, using the inputs the DUT sampled.
    task automatic model_edge();
        bit raw [3];
        bit ps, pl, pc, tk, flip, counting;
        int nc;
        if (reset) begin
            model_reset();
            return;
        end
        raw[0] = btn_start; raw[1] = btn_lap; raw[2] = btn_clear;
        ps = m_pulse[0];
        pl = m_pulse[1] && !ps;
        pc = m_pulse[2] && !ps && !m_pulse[1];
        counting = (m_state == S_RUN) || (m_state == S_LAP);
        tk = counting && (m_phase == TICK_DIV - 1);
        nc = tk ? (m_count + 1) % 10000 : m_count;
        m_wrap = tk && (m_count == 9999);
        if (counting)               m_phase = tk ? 0 : m_phase + 1;
        else if (m_state == S_IDLE) m_phase = 0;
        m_count = nc;
        case (m_state)
            S_IDLE:  if (ps) m_state = S_RUN;
            S_RUN:   if (ps) m_state = S_PAUSE;
                     else if (pl) begin m_state = S_LAP; m_lap = nc; end
            S_LAP:   if (ps) m_state = S_PAUSE;
                     else if (pl) m_state = S_RUN;
            S_PAUSE: if (ps) m_state = S_RUN;
                     else if (pc) begin
                         m_state = S_IDLE; m_count = 0; m_lap = 0; m_phase = 0;
                     end
            default: m_state = S_IDLE;
        endcase
        // Level flips once the synced input (2 samples late) has differed DEB times running.
        for (int b = 0; b < 3; b++) begin
            for (int k = 15; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
            m_hist[b][0] = raw[b];
            flip = 1'b1;
            for (int k = 2; k <= DEB + 1; k++) if (m_hist[b][k] == m_lvl[b]) flip = 1'b0;
            m_pulse[b] = m_rose[b];
            m_rose[b]  = flip && !m_lvl[b];
            if (flip) m_lvl[b] = !m_lvl[b];
        end
    endtask

    task automatic compare_all();
        int shown;
        shown = (m_state == S_LAP) ? m_lap : m_count;
        chk("digits", disp(), to_bcd(shown));
        chk("running", 16'(running), 16'(m_state == S_RUN || m_state == S_LAP));
        chk("lap_active", 16'(lap_active), 16'(m_state == S_LAP));
        chk("wrap", 16'(wrap), 16'(m_wrap));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_100MHz);
            model_edge();
            @(negedge clk_100MHz);
            compare_all();
        end
    endtask

    // Hold the chosen buttons for 8 cycles; the FSM acts on the 8th edge.
    task automatic press(input bit s, input bit l, input bit c);
        btn_start = s; btn_lap = l; btn_clear = c;
        step(8);
        btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    endtask

    initial begin
        int r;
        model_reset();

        // Reset held 3 cycles, then idle
        step(3);
        chk("rst_digits", disp(), 16'h0000);
        chk("rst_running", 16'(running), 16'h0);
        chk("rst_lap_active", 16'(lap_active), 16'h0);
        chk("rst_wrap", 16'(wrap), 16'h0);
        reset = 1'b0;
        step(100);
        chk("idle_digits", disp(), 16'h0000);
        chk("idle_running", 16'(running), 16'h0);

        // Debounce: 3-cycle glitch ignored, then a real press
        btn_start = 1'b1;
        step(3);
        btn_start = 1'b0;
        step(20);
        chk("glitch_running", 16'(running), 16'h0);
        btn_start = 1'b1;
        step(7);
        chk("press_early", 16'(running), 16'h0);
        step(1);
        chk("press_latency", 16'(running), 16'h1);
        step(2);
        btn_start = 1'b0;
        step(7);
        chk("first_tick_before", disp(), 16'h0000);
        step(1);
        chk("first_tick", disp(), 16'h0001);
        step(25);
        chk("run35", disp(), 16'h0003);

        // Pause, hold, resume with preserved prescaler, pause and clear
        press(1, 0, 0);
        chk("pause_running", 16'(running), 16'h0);
        chk("pause_digits", disp(), 16'h0004);
        step(200);
        chk("pause_hold", disp(), 16'h0004);
        press(1, 0, 0);
        chk("resume_running", 16'(running), 16'h1);
        step(6);
        chk("resume_pre", disp(), 16'h0004);
        step(1);
        chk("resume_tick", disp(), 16'h0005);
        step(10);
        press(1, 0, 0);
        step(10);
        press(0, 0, 1);
        chk("clear_digits", disp(), 16'h0000);
        chk("clear_running", 16'(running), 16'h0);

        // Lap freeze, lap release, lap then start
        press(1, 0, 0);
        step(115);
        press(0, 1, 0);
        chk("lap_freeze", disp(), 16'h0012);
        chk("lap_active_on", 16'(lap_active), 16'h1);
        step(30);
        chk("lap_frozen", disp(), 16'h0012);
        chk("lap_running", 16'(running), 16'h1);
        step(42);
        press(0, 1, 0);
        chk("lap_release", disp(), 16'h0020);
        chk("lap_active_off", 16'(lap_active), 16'h0);
        step(10);
        press(0, 1, 0);
        step(10);
        press(1, 0, 0);
        chk("lap_to_pause", disp(), 16'h0023);
        chk("lap_to_pause_la", 16'(lap_active), 16'h0);
        chk("lap_to_pause_run", 16'(running), 16'h0);
        step(10);
        press(0, 0, 1);

        // Simultaneous start+lap in RUN: start wins
        step(10);
        press(1, 0, 0);
        step(20);
        press(1, 1, 0);
        chk("simul_running", 16'(running), 16'h0);
        chk("simul_lap_active", 16'(lap_active), 16'h0);
        step(10);
        press(0, 0, 1);
        step(10);

        // Random button activity with occasional resets
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) btn_start = ~btn_start;
            if (r == 1) btn_lap   = ~btn_lap;
            if (r == 2) btn_clear = ~btn_clear;
            reset = ($urandom_range(0, 599) == 0);
            step(1);
        end
        btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(10);

        // Rollover on the fast instance
        w_start = 1'b1;
        step(8);
        w_start = 1'b0;
        chk("w_running", 16'(w_running), 16'h1);
        step(19996);
        chk("w_9998", w_disp(), 16'h9998);
        step(2);
        chk("w_9999", w_disp(), 16'h9999);
        chk("w_wrap_pre", 16'(w_wrap), 16'h0);
        step(2);
        chk("w_0000", w_disp(), 16'h0000);
        chk("w_wrap", 16'(w_wrap), 16'h1);
        step(1);
        chk("w_wrap_once", 16'(w_wrap), 16'h0);
        step(1);
        chk("w_0001", w_disp(), 16'h0001);

        // Reset mid-run at 0047
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(10);
        press(1, 0, 0);
        step(470);
        chk("run_47", disp(), 16'h0047);
        reset = 1'b1;
        step(1);
        chk("midrst_digits", disp(), 16'h0000);
        chk("midrst_running", 16'(running), 16'h0);
        chk("midrst_w_digits", w_disp(), 16'h0000);
        reset = 1'b0;
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
